pwm_audio_out: RTL and testbench

- Downstream consumer of the song ROM data byte.
- Each sample period it requests one 8-bit sample and scales it by the BCD volume from the volume controller.
- It drives a single-bit PWM audio output.
- Its sample_req pulse is the "count" strobe that advances the current-address state machine, so the ROM address moves exactly once per consumed sample.

---
 rtl/pwm_audio_out_pkg.sv | 26 ++
 rtl/pwm_audio_out_if.sv | 24 ++
 rtl/pwm_audio_out_volume_scaler.sv | 83 ++++++++
 rtl/pwm_audio_out.sv | 86 ++++++++
 tb/tb_pwm_audio_out.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_audio_out_pkg.sv
// Shared constants, scaler state encoding and the BCD volume decode used by the PWM audio path.
// Pure definitions: no state, no latency, no flow control.
package pwm_audio_out_pkg;

   localparam logic [7:0] SILENCE      = 8'd128;
   localparam int         PWM_BITS_DEF = 8;
   localparam int         MUL_STEPS    = 7;

   typedef enum logic [1:0] {
      SC_IDLE = 2'd0,
      SC_MUL  = 2'd1,
      SC_DONE = 2'd2
   } scaler_state_e;

   function automatic logic [3:0] bcd_sat(input logic [3:0] digit);
      return (digit > 4'd9) ? 4'd9 : digit;
   endfunction

   // Maps 0..99 onto roughly 0..127 so a full-scale product shifts down by 7 with no divide.
   function automatic logic [6:0] vol_quant(input logic [3:0] tens, input logic [3:0] units);
      logic [6:0] vol;
      vol = 7'(bcd_sat(tens)) * 7'd10 + 7'(bcd_sat(units));
      return vol + (vol >> 2) + (vol >> 5);
   endfunction

endpackage

// File: rtl/pwm_audio_out_if.sv
// Play/sample/volume inputs and PWM status outputs of the audio output block.
// Plain level signals; sample_req is the only strobe and has no backpressure.
interface pwm_audio_out_if;

   logic       play;
   logic [7:0] sample;
   logic [3:0] volume1;
   logic [3:0] volume0;
   logic       sample_req;
   logic       pwm_out;
   logic [7:0] duty;
   logic       busy;

   modport master (
      output play, sample, volume1, volume0,
      input  sample_req, pwm_out, duty, busy
   );

   modport slave (
      input  play, sample, volume1, volume0,
      output sample_req, pwm_out, duty, busy
   );

endinterface

// File: rtl/pwm_audio_out_volume_scaler.sv
// Latches sample and BCD volume on start, then multiplies (sample-128) by the quantised volume.
// Latency: 7 shift-add cycles plus one DONE cycle; start is ignored while busy, no backpressure.
module pwm_audio_out_volume_scaler
   import pwm_audio_out_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] sample,
   input  logic [3:0] volume1,
   input  logic [3:0] volume0,
   output logic       busy,
   output logic       done,
   output logic [7:0] result
);

   scaler_state_e state_q, state_d;
   logic [2:0]    step_q, step_d;
   logic [8:0]    mcand_q, mcand_d;
   logic [6:0]    mplier_q, mplier_d;
   logic [8:0]    acc_q, acc_d;
   logic [8:0]    diff;
   logic [9:0]    addend;

   assign diff   = {1'b0, sample} - 9'd128;
   assign addend = mplier_q[0] ? {mcand_q[8], mcand_q} : 10'd0;

   // The accumulator shifts right each step, so the 7 product LSBs fall off and
   // acc ends up holding floor(d * vol_q / 128) directly.
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      case (state_q)
         SC_IDLE: begin
            if (start) begin
               mcand_d  = diff;
               mplier_d = vol_quant(volume1, volume0);
               acc_d    = '0;
               step_d   = '0;
               state_d  = SC_MUL;
            end
         end
         SC_MUL: begin
            acc_d    = 9'($signed({acc_q[8], acc_q} + addend) >>> 1);
            mplier_d = mplier_q >> 1;
            step_d   = step_q + 3'd1;
            if (step_q == 3'(MUL_STEPS - 1)) begin
               state_d = SC_DONE;
            end
         end
         SC_DONE: begin
            state_d = SC_IDLE;
         end
         default: begin
            state_d = SC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= SC_IDLE;
         step_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

   assign busy   = (state_q != SC_IDLE);
   assign done   = (state_q == SC_DONE);
   assign result = SILENCE + acc_q[7:0];

endmodule

// File: rtl/pwm_audio_out.sv
// Free-running PWM audio output; requests one volume-scaled sample every OVERSAMPLE PWM periods.
// Latency: a sample captured at one boundary plays from the next; sample_req cannot be stalled.
module pwm_audio_out
   import pwm_audio_out_pkg::*;
#(
   parameter int OVERSAMPLE = 1,
   parameter int PWM_BITS   = PWM_BITS_DEF
) (
   input  logic             clk,
   input  logic             reset,
   pwm_audio_out_if.slave   aud
);

   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [3:0]          os_cnt_q, os_cnt_d;
   logic [7:0]          duty_q, duty_d;
   logic [7:0]          duty_next_q, duty_next_d;
   logic                pwm_out_q, pwm_out_d;
   logic [7:0]          pwm_phase;
   logic                boundary;
   logic                sample_req;
   logic                sc_busy;
   logic                sc_done;
   logic [7:0]          sc_result;

   // Duty is 8 bits; wider counters compare on their top 8 bits.
   assign pwm_phase  = pwm_cnt_q[PWM_BITS-1 -: 8];
   assign boundary   = &pwm_cnt_q;
   assign sample_req = boundary && aud.play && (os_cnt_q == 4'd0) && !reset;

   always_comb begin
      pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
      pwm_out_d   = (pwm_phase < duty_q);
      os_cnt_d    = os_cnt_q;
      duty_d      = duty_q;
      duty_next_d = duty_next_q;
      if (sc_done) begin
         duty_next_d = sc_result;
      end
      // Pausing clears duty_next as well, so a resume never replays a stale sample.
      if (boundary) begin
         if (aud.play) begin
            duty_d   = duty_next_q;
            os_cnt_d = (os_cnt_q == 4'(OVERSAMPLE - 1)) ? 4'd0 : os_cnt_q + 4'd1;
         end else begin
            duty_d      = SILENCE;
            duty_next_d = SILENCE;
            os_cnt_d    = 4'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt_q   <= '0;
         os_cnt_q    <= '0;
         duty_q      <= SILENCE;
         duty_next_q <= SILENCE;
         pwm_out_q   <= 1'b0;
      end else begin
         pwm_cnt_q   <= pwm_cnt_d;
         os_cnt_q    <= os_cnt_d;
         duty_q      <= duty_d;
         duty_next_q <= duty_next_d;
         pwm_out_q   <= pwm_out_d;
      end
   end

   pwm_audio_out_volume_scaler u_scaler (
      .clk     (clk),
      .reset   (reset),
      .start   (sample_req),
      .sample  (aud.sample),
      .volume1 (aud.volume1),
      .volume0 (aud.volume0),
      .busy    (sc_busy),
      .done    (sc_done),
      .result  (sc_result)
   );

   assign aud.sample_req = sample_req;
   assign aud.pwm_out    = pwm_out_q;
   assign aud.duty       = duty_q;
   assign aud.busy       = sc_busy;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Scoreboard bench: two instances (OVERSAMPLE 1 and 4) share random per-period stimulus;
// a per-boundary reference model queues expected requests and duties for a negedge monitor.
module tb_pwm_audio_out;

   localparam int NDIR = 14;
   localparam int NRND = 16;
   localparam int NB   = NDIR + NRND;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   nchk  = 0;
   int   nerr  = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

   pwm_audio_out_if aud1();
   pwm_audio_out_if aud4();

   pwm_audio_out #(.OVERSAMPLE(1), .PWM_BITS(8)) dut1 (.clk(clk), .reset(reset), .aud(aud1));
   pwm_audio_out #(.OVERSAMPLE(4), .PWM_BITS(8)) dut4 (.clk(clk), .reset(reset), .aud(aud4));

   logic       sreq[2];
   logic       pwo[2];
   logic       bsy[2];
   logic [7:0] dty[2];
   assign sreq[0] = aud1.sample_req;
   assign sreq[1] = aud4.sample_req;
   assign pwo[0]  = aud1.pwm_out;
   assign pwo[1]  = aud4.pwm_out;
   assign bsy[0]  = aud1.busy;
   assign bsy[1]  = aud4.busy;
   assign dty[0]  = aud1.duty;
   assign dty[1]  = aud4.duty;

   // Directed rows first: silence, full-scale +/-, half volume, mute, pause, resume, bad BCD.
   int t_play[NDIR] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
   int t_smp[NDIR]  = '{0, 0, 0, 0, 255, 0, 192, 192, 255, 255, 255, 0, 64, 200};
   int t_v1[NDIR]   = '{0, 0, 0, 0, 9, 9, 5, 0, 9, 9, 9, 9, 12, 3};
   int t_v0[NDIR]   = '{0, 0, 0, 0, 9, 9, 0, 0, 9, 9, 9, 9, 15, 7};

   int rq0[$];
   int rq1[$];
   int dq0[$];
   int dq1[$];

   int m_os[2] = '{0, 0};
   int m_dn[2] = '{128, 128};

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int scale_ref(input int s, input int t, input int u);
      int a, b, vol, vq, p, q;
      a   = (t > 9) ? 9 : t;
      b   = (u > 9) ? 9 : u;
      vol = 10 * a + b;
      vq  = vol + vol / 4 + vol / 32;
      p   = (s - 128) * vq;
      q   = (p >= 0) ? p / 128 : -((-p + 127) / 128);
      return 128 + q;
   endfunction

   function automatic int pop_req(input int i);
      if (i == 0) begin
         if (rq0.size() == 0) return -1;
         return rq0.pop_front();
      end
      if (rq1.size() == 0) return -1;
      return rq1.pop_front();
   endfunction

   function automatic int pop_duty(input int i);
      if (i == 0) begin
         if (dq0.size() == 0) return -1;
         return dq0.pop_front();
      end
      if (dq1.size() == 0) return -1;
      return dq1.pop_front();
   endfunction

   // Reference: what each boundary does, given the inputs present in that cycle.
   task automatic model_boundary(input int play, input int s, input int t, input int u);
      for (int i = 0; i < 2; i++) begin
         int osn;
         int req;
         osn = (i == 0) ? 1 : 4;
         req = (play != 0 && m_os[i] == 0) ? 1 : 0;
         if (play != 0) begin
            if (i == 0) dq0.push_back(m_dn[i]); else dq1.push_back(m_dn[i]);
            m_os[i] = (m_os[i] + 1) % osn;
         end else begin
            if (i == 0) dq0.push_back(128); else dq1.push_back(128);
            m_dn[i] = 128;
            m_os[i] = 0;
         end
         if (req != 0) begin
            if (i == 0) rq0.push_back(cyc); else rq1.push_back(cyc);
            m_dn[i] = scale_ref(s, t, u);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) tick();
   endtask

   task automatic set_play(input int p);
      aud1.play = (p != 0);
      aud4.play = (p != 0);
   endtask

   task automatic set_smp(input int s, input int t, input int u);
      aud1.sample  = 8'(s);
      aud4.sample  = 8'(s);
      aud1.volume1 = 4'(t);
      aud4.volume1 = 4'(t);
      aud1.volume0 = 4'(u);
      aud4.volume0 = 4'(u);
   endtask

   int hi[2]   = '{0, 0};
   int win[2]  = '{128, 128};
   int pend[2] = '{128, 128};
   int brun[2] = '{0, 0};

   always @(negedge clk) begin
      int e;
      if (mon_en && !reset) begin
         for (int i = 0; i < 2; i++) begin
            if (sreq[i]) begin
               e = pop_req(i);
               chk($sformatf("sample_req_cycle[inst%0d]", i), cyc, e);
            end
            if (bsy[i]) begin
               brun[i]++;
            end else if (brun[i] > 0) begin
               chk($sformatf("busy_len[inst%0d]", i), brun[i], 8);
               brun[i] = 0;
            end
            if (cyc % 256 == 0 && cyc > 0) begin
               e = pop_duty(i);
               chk($sformatf("duty[inst%0d]", i), int'(dty[i]), e);
               pend[i] = e;
            end
            if (cyc % 256 == 1) begin
               if (cyc > 1) chk($sformatf("pwm_high_count[inst%0d]", i), hi[i], win[i]);
               win[i] = pend[i];
               hi[i]  = 0;
            end
            hi[i] += int'(pwo[i]);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: run exceeded its time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p, s, t, u, c0;
      set_play(0);
      set_smp(128, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("reset_duty[inst%0d]", i), int'(dty[i]), 128);
         chk($sformatf("reset_pwm_out[inst%0d]", i), int'(pwo[i]), 0);
         chk($sformatf("reset_busy[inst%0d]", i), int'(bsy[i]), 0);
         chk($sformatf("reset_sample_req[inst%0d]", i), int'(sreq[i]), 0);
      end
      @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      for (int k = 0; k < NB; k++) begin
         if (k < NDIR) begin
            p = t_play[k];
            s = t_smp[k];
            t = t_v1[k];
            u = t_v0[k];
         end else begin
            p = ($urandom_range(0, 3) != 0) ? 1 : 0;
            s = int'($urandom_range(0, 255));
            t = int'($urandom_range(0, 11));
            u = int'($urandom_range(0, 11));
         end
         wait_cyc(256 * k + 100);
         set_play(p);
         wait_cyc(256 * k + 200);
         set_smp(s, t, u);
         wait_cyc(256 * k + 255);
         model_boundary(p, s, t, u);
         // Operands change while the scaler is busy; only the captured values may count.
         wait_cyc(256 * k + 258);
         set_smp(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)));
      end
      wait_cyc(256 * NB + 20);
      chk("sample_req_queue_drained", rq0.size() + rq1.size(), 0);
      chk("duty_queue_drained", dq0.size() + dq1.size(), 0);
      mon_en = 1'b0;

      // Reset four cycles into a multiplication must abort it without a duty_next write.
      set_play(1);
      set_smp(255, 9, 9);
      c0 = -1;
      for (int i = 0; i < 600 && c0 < 0; i++) begin
         @(negedge clk);
         if (aud1.sample_req) c0 = cyc;
      end
      chk("abort_sample_req_seen", (c0 >= 0) ? 1 : 0, 1);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busy_before_reset", int'(aud1.busy), 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("abort_busy_after[inst%0d]", i), int'(bsy[i]), 0);
         chk($sformatf("abort_duty_after[inst%0d]", i), int'(dty[i]), 128);
      end
      wait_cyc(256);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("abort_duty_next_load[inst%0d]", i), int'(dty[i]), 128);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule
